// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: result kinds, forwarding
// mux select codes and the Tnew lookup used by the stall comparison.
package hazard_pkg;

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_PC8  = 2'd1;
    localparam logic [1:0] KIND_ALU  = 2'd2;
    localparam logic [1:0] KIND_MEM  = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] STG_E = 2'd0;
    localparam logic [1:0] STG_M = 2'd1;
    localparam logic [1:0] STG_W = 2'd2;

    localparam logic [2:0] FWD_D_REG   = 3'd0;
    localparam logic [2:0] FWD_D_PC8_E = 3'd1;
    localparam logic [2:0] FWD_D_PC8_M = 3'd2;
    localparam logic [2:0] FWD_D_AO_M  = 3'd3;

    localparam logic [2:0] FWD_E_REG   = 3'd0;
    localparam logic [2:0] FWD_E_PC8_M = 3'd1;
    localparam logic [2:0] FWD_E_AO_M  = 3'd2;
    localparam logic [2:0] FWD_E_WD    = 3'd3;

    localparam logic [2:0] FWD_M_REG   = 3'd0;
    localparam logic [2:0] FWD_M_WD    = 3'd1;

    // Cycles until a result of the given kind becomes available from the given stage.
    function automatic logic [1:0] tnew(input logic [1:0] kind, input logic [1:0] stage);
        logic [1:0] t;
        t = 2'd0;
        case (kind)
            KIND_ALU: t = (stage == STG_E) ? 2'd1 : 2'd0;
            KIND_MEM: t = (stage == STG_E) ? 2'd2 : ((stage == STG_M) ? 2'd1 : 2'd0);
            default:  t = 2'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hazard_port_check.sv
// Per-read-port hazard check: stall request plus the D/E/M forwarding selects
// for one source register as it travels down the pipeline.
module hazard_port_check
    import hazard_pkg::*;
(
    input  logic [4:0] reg_D,
    input  logic [1:0] tuse_D,
    input  logic [4:0] reg_E,
    input  logic [4:0] reg_M,
    input  logic [4:0] a3_E,
    input  logic [1:0] kind_E,
    input  logic [4:0] a3_M,
    input  logic [1:0] kind_M,
    input  logic [4:0] a3_W,
    output logic       stall_req,
    output logic [2:0] fwd_D,
    output logic [2:0] fwd_E,
    output logic [2:0] fwd_M
);

    logic hit_e_d, hit_m_d, hit_m_e, hit_w_e, hit_w_m;

    // $0 never matches: captured writers to $0 already carry a3=0.
    assign hit_e_d = (reg_D != 5'd0) && (a3_E == reg_D);
    assign hit_m_d = (reg_D != 5'd0) && (a3_M == reg_D);
    assign hit_m_e = (reg_E != 5'd0) && (a3_M == reg_E);
    assign hit_w_e = (reg_E != 5'd0) && (a3_W == reg_E);
    assign hit_w_m = (reg_M != 5'd0) && (a3_W == reg_M);

    always_comb begin
        stall_req = 1'b0;
        if (tuse_D != TUSE_NONE) begin
            if ((hit_e_d && (tnew(kind_E, STG_E) > tuse_D)) ||
                (hit_m_d && (tnew(kind_M, STG_M) > tuse_D))) begin
                stall_req = 1'b1;
            end
        end
    end

    // A match in E shadows any older M result even when E's value is not ready yet.
    always_comb begin
        fwd_D = FWD_D_REG;
        if (hit_e_d) begin
            if (kind_E == KIND_PC8) fwd_D = FWD_D_PC8_E;
        end else if (hit_m_d) begin
            case (kind_M)
                KIND_PC8: fwd_D = FWD_D_PC8_M;
                KIND_ALU: fwd_D = FWD_D_AO_M;
                default:  fwd_D = FWD_D_REG;
            endcase
        end
    end

    always_comb begin
        fwd_E = FWD_E_REG;
        if (hit_m_e) begin
            case (kind_M)
                KIND_PC8: fwd_E = FWD_E_PC8_M;
                KIND_ALU: fwd_E = FWD_E_AO_M;
                default:  fwd_E = FWD_E_REG;
            endcase
        end else if (hit_w_e) begin
            fwd_E = FWD_E_WD;
        end
    end

    assign fwd_M = hit_w_m ? FWD_M_WD : FWD_M_REG;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: holds the E/M/W stage
// bookkeeping, derives the stall and per-port forwarding selects, counts stalls.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rd_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [1:0]       tuse_rd_D,
    input  logic [4:0]       a3_D,
    input  logic [1:0]       kind_D,
    input  logic             flush_E,
    output logic             stall,
    output logic [2:0]       fwd_rs_D,
    output logic [2:0]       fwd_rt_D,
    output logic [2:0]       fwd_rd_D,
    output logic [2:0]       fwd_rs_E,
    output logic [2:0]       fwd_rt_E,
    output logic [2:0]       fwd_rd_E,
    output logic [2:0]       fwd_rs_M,
    output logic [2:0]       fwd_rt_M,
    output logic [2:0]       fwd_rd_M,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0] rs_e_q, rt_e_q, rd_e_q, a3_e_q;
    logic [4:0] rs_e_d, rt_e_d, rd_e_d, a3_e_d;
    logic [1:0] kind_e_q, kind_e_d;
    logic [4:0] rs_m_q, rt_m_q, rd_m_q, a3_m_q;
    logic [4:0] rs_m_d, rt_m_d, rd_m_d, a3_m_d;
    logic [1:0] kind_m_q, kind_m_d;
    logic [4:0] a3_w_q, a3_w_d;
    logic [1:0] kind_w_q, kind_w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [2:0][4:0] src_D, src_E, src_M;
    logic [2:0][1:0] tuse_D;
    logic [2:0]      stall_req;
    logic [2:0][2:0] fwd_D, fwd_E, fwd_M;
    logic            writes_D;

    assign src_D  = {rd_D, rt_D, rs_D};
    assign src_E  = {rd_e_q, rt_e_q, rs_e_q};
    assign src_M  = {rd_m_q, rt_m_q, rs_m_q};
    assign tuse_D = {tuse_rd_D, tuse_rt_D, tuse_rs_D};

    for (genvar p = 0; p < 3; p++) begin : g_port
        hazard_port_check u_chk (
            .reg_D     (src_D[p]),
            .tuse_D    (tuse_D[p]),
            .reg_E     (src_E[p]),
            .reg_M     (src_M[p]),
            .a3_E      (a3_e_q),
            .kind_E    (kind_e_q),
            .a3_M      (a3_m_q),
            .kind_M    (kind_m_q),
            .a3_W      (a3_w_q),
            .stall_req (stall_req[p]),
            .fwd_D     (fwd_D[p]),
            .fwd_E     (fwd_E[p]),
            .fwd_M     (fwd_M[p])
        );
    end

    assign stall = |stall_req;
    assign {fwd_rd_D, fwd_rt_D, fwd_rs_D} = fwd_D;
    assign {fwd_rd_E, fwd_rt_E, fwd_rs_E} = fwd_E;
    assign {fwd_rd_M, fwd_rt_M, fwd_rs_M} = fwd_M;
    assign stall_cnt = stall_cnt_q;

    // A writer to $0 or with no result is normalised so it can never match.
    assign writes_D = (a3_D != 5'd0) && (kind_D != KIND_NONE);

    always_comb begin
        rs_e_d   = 5'd0;
        rt_e_d   = 5'd0;
        rd_e_d   = 5'd0;
        a3_e_d   = 5'd0;
        kind_e_d = KIND_NONE;
        if (!stall && !flush_E) begin
            rs_e_d   = rs_D;
            rt_e_d   = rt_D;
            rd_e_d   = rd_D;
            a3_e_d   = writes_D ? a3_D : 5'd0;
            kind_e_d = writes_D ? kind_D : KIND_NONE;
        end

        rs_m_d   = rs_e_q;
        rt_m_d   = rt_e_q;
        rd_m_d   = rd_e_q;
        a3_m_d   = a3_e_q;
        kind_m_d = kind_e_q;
        a3_w_d   = a3_m_q;
        kind_w_d = kind_m_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_e_q      <= 5'd0;
            rt_e_q      <= 5'd0;
            rd_e_q      <= 5'd0;
            a3_e_q      <= 5'd0;
            kind_e_q    <= KIND_NONE;
            rs_m_q      <= 5'd0;
            rt_m_q      <= 5'd0;
            rd_m_q      <= 5'd0;
            a3_m_q      <= 5'd0;
            kind_m_q    <= KIND_NONE;
            a3_w_q      <= 5'd0;
            kind_w_q    <= KIND_NONE;
            stall_cnt_q <= '0;
        end else begin
            rs_e_q      <= rs_e_d;
            rt_e_q      <= rt_e_d;
            rd_e_q      <= rd_e_d;
            a3_e_q      <= a3_e_d;
            kind_e_q    <= kind_e_d;
            rs_m_q      <= rs_m_d;
            rt_m_q      <= rt_m_d;
            rd_m_q      <= rd_m_d;
            a3_m_q      <= a3_m_d;
            kind_m_q    <= kind_m_d;
            a3_w_q      <= a3_w_d;
            kind_w_q    <= kind_w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // W kind is kept for debug visibility of the retiring instruction.
    logic unused_w;
    assign unused_w = ^kind_w_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: expectations queued as each D-stage input
// is applied, then drained and compared at the following falling edge.
module tb_hazard_fwd_ctrl;
    import hazard_pkg::*;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       rs_D, rt_D, rd_D, a3_D;
    logic [1:0]       tuse_rs_D, tuse_rt_D, tuse_rd_D, kind_D;
    logic             flush_E;
    logic             stall;
    logic [2:0]       fwd_rs_D, fwd_rt_D, fwd_rd_D;
    logic [2:0]       fwd_rs_E, fwd_rt_E, fwd_rd_E;
    logic [2:0]       fwd_rs_M, fwd_rt_M, fwd_rd_M;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .tuse_rd_D(tuse_rd_D),
        .a3_D(a3_D), .kind_D(kind_D), .flush_E(flush_E),
        .stall(stall),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rd_D(fwd_rd_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rd_E(fwd_rd_E),
        .fwd_rs_M(fwd_rs_M), .fwd_rt_M(fwd_rt_M), .fwd_rd_M(fwd_rd_M),
        .stall_cnt(stall_cnt)
    );

    localparam int S_STALL = 0, S_CNT = 1;
    localparam int S_RS_D = 2, S_RT_D = 3, S_RD_D = 4;
    localparam int S_RS_E = 5, S_RT_E = 6, S_RD_E = 7;
    localparam int S_RS_M = 8, S_RT_M = 9, S_RD_M = 10;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] obs(input int sel);
        logic [31:0] v;
        v = '0;
        case (sel)
            S_STALL: v = {31'd0, stall};
            S_CNT:   v = {{(32-CNT_W){1'b0}}, stall_cnt};
            S_RS_D:  v = {29'd0, fwd_rs_D};
            S_RT_D:  v = {29'd0, fwd_rt_D};
            S_RD_D:  v = {29'd0, fwd_rd_D};
            S_RS_E:  v = {29'd0, fwd_rs_E};
            S_RT_E:  v = {29'd0, fwd_rt_E};
            S_RD_E:  v = {29'd0, fwd_rd_E};
            S_RS_M:  v = {29'd0, fwd_rs_M};
            S_RT_M:  v = {29'd0, fwd_rt_M};
            S_RD_M:  v = {29'd0, fwd_rd_M};
            default: v = 32'hdead_beef;
        endcase
        return v;
    endfunction

    task automatic push_exp(input string tag, input int sel, input int e);
        exp_t x;
        x.sel = sel;
        x.exp = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [31:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = obs(x.sel);
            checks++;
            assert (o === x.exp) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", x.tag, o, x.exp);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int rs, input int rt, input int rd,
                        input int trs, input int trt, input int trd,
                        input int a3, input logic [1:0] kind, input logic fl);
        rs_D = 5'(rs); rt_D = 5'(rt); rd_D = 5'(rd);
        tuse_rs_D = 2'(trs); tuse_rt_D = 2'(trt); tuse_rd_D = 2'(trd);
        a3_D = 5'(a3); kind_D = kind; flush_E = fl;
    endtask

    task automatic idle();
        setd(0, 0, 0, 3, 3, 3, 0, KIND_NONE, 1'b0);
    endtask

    initial begin
        idle();
        #2;
        push_exp("reset_stall", S_STALL, 0);
        push_exp("reset_cnt", S_CNT, 0);
        push_exp("reset_rs_e", S_RS_E, 0);
        push_exp("reset_rt_m", S_RT_M, 0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU result feeding a branch comparison in D
        setd(1, 2, 0, 1, 1, 3, 5, KIND_ALU, 1'b0);
        push_exp("alu_br_writer_nostall", S_STALL, 0);
        step();
        setd(5, 6, 0, 0, 0, 3, 0, KIND_NONE, 1'b0);
        push_exp("alu_br_stall", S_STALL, 1);
        push_exp("alu_br_cnt0", S_CNT, 0);
        step();
        push_exp("alu_br_release", S_STALL, 0);
        push_exp("alu_br_fwd_rs_d", S_RS_D, 3);
        push_exp("alu_br_fwd_rt_d", S_RT_D, 0);
        push_exp("alu_br_cnt1", S_CNT, 1);
        step();
        idle();
        push_exp("alu_br_fwd_rs_e_wd", S_RS_E, 3);
        step();

        // load-use and store data
        setd(1, 0, 0, 1, 3, 3, 8, KIND_MEM, 1'b0);
        push_exp("lu_lw_nostall", S_STALL, 0);
        step();
        setd(8, 9, 0, 1, 1, 3, 10, KIND_ALU, 1'b0);
        push_exp("lu_stall", S_STALL, 1);
        step();
        push_exp("lu_release", S_STALL, 0);
        push_exp("lu_fwd_rs_d_mem", S_RS_D, 0);
        push_exp("lu_cnt2", S_CNT, 2);
        step();
        idle();
        push_exp("lu_fwd_rs_e_wd", S_RS_E, 3);
        step();
        setd(1, 0, 0, 1, 3, 3, 8, KIND_MEM, 1'b0);
        step();
        setd(1, 8, 0, 1, 2, 3, 0, KIND_NONE, 1'b0);
        push_exp("sw_nostall", S_STALL, 0);
        step();
        idle();
        push_exp("sw_fwd_rt_e_deferred", S_RT_E, 0);
        step();
        push_exp("sw_fwd_rt_m_wd", S_RT_M, 1);
        step();

        // jal then jr: PC+8 from E, then from M
        setd(0, 0, 0, 3, 3, 3, 31, KIND_PC8, 1'b0);
        step();
        setd(31, 0, 0, 0, 3, 3, 0, KIND_NONE, 1'b0);
        push_exp("jr_nostall_e", S_STALL, 0);
        push_exp("jr_fwd_pc8_e", S_RS_D, 1);
        step();
        push_exp("jr_nostall_m", S_STALL, 0);
        push_exp("jr_fwd_pc8_m", S_RS_D, 2);
        step();
        idle();
        push_exp("jr_fwd_rs_e_wd", S_RS_E, 3);
        step();

        // younger M result beats older W result
        setd(0, 0, 0, 3, 3, 3, 3, KIND_ALU, 1'b0);
        step();
        setd(0, 0, 0, 3, 3, 3, 3, KIND_ALU, 1'b0);
        step();
        setd(3, 0, 3, 1, 3, 1, 4, KIND_ALU, 1'b0);
        push_exp("prio_nostall", S_STALL, 0);
        step();
        idle();
        push_exp("prio_fwd_rs_e_aom", S_RS_E, 2);
        push_exp("prio_fwd_rd_e_aom", S_RD_E, 2);
        step();
        push_exp("prio_fwd_rs_m_wd", S_RS_M, 1);
        push_exp("prio_fwd_rd_m_wd", S_RD_M, 1);
        step();

        // $0 and kind=none writers never forward
        setd(0, 0, 0, 3, 3, 3, 0, KIND_ALU, 1'b0);
        step();
        setd(0, 0, 0, 0, 0, 3, 0, KIND_NONE, 1'b0);
        push_exp("zero_nostall", S_STALL, 0);
        push_exp("zero_fwd_rs_d", S_RS_D, 0);
        step();
        idle();
        push_exp("zero_fwd_rs_e", S_RS_E, 0);
        step();
        push_exp("zero_fwd_rs_m", S_RS_M, 0);
        step();
        setd(0, 0, 0, 3, 3, 3, 7, KIND_NONE, 1'b0);
        step();
        idle();
        step();
        setd(7, 0, 0, 1, 3, 3, 0, KIND_NONE, 1'b0);
        push_exp("none_nostall", S_STALL, 0);
        step();
        idle();
        push_exp("none_fwd_rs_e", S_RS_E, 0);
        step();

        // flush_E alone, then flush_E together with a load-use stall
        setd(0, 0, 0, 3, 3, 3, 14, KIND_ALU, 1'b1);
        step();
        setd(14, 0, 0, 0, 3, 3, 0, KIND_NONE, 1'b0);
        push_exp("flush_bubble_nostall", S_STALL, 0);
        push_exp("flush_bubble_fwd_rs_d", S_RS_D, 0);
        step();
        setd(0, 0, 0, 3, 3, 3, 12, KIND_MEM, 1'b0);
        step();
        setd(12, 0, 0, 0, 3, 3, 13, KIND_ALU, 1'b1);
        push_exp("flush_stall_e", S_STALL, 1);
        push_exp("flush_stall_cnt2", S_CNT, 2);
        step();
        setd(12, 0, 0, 0, 3, 3, 13, KIND_ALU, 1'b0);
        push_exp("flush_stall_m", S_STALL, 1);
        push_exp("flush_stall_cnt3", S_CNT, 3);
        step();
        push_exp("flush_release", S_STALL, 0);
        push_exp("flush_fwd_rs_d_nowb", S_RS_D, 0);
        push_exp("flush_cnt4", S_CNT, 4);
        step();
        idle();
        push_exp("flush_fwd_rs_e", S_RS_E, 0);
        step();

        // drive the counter past all-ones
        for (int i = 0; i < 2; i++) begin
            setd(0, 0, 0, 3, 3, 3, 12, KIND_MEM, 1'b0);
            step();
            setd(12, 0, 0, 0, 3, 3, 0, KIND_NONE, 1'b0);
            step();
            step();
            step();
            idle();
            step();
        end
        push_exp("cnt_saturated", S_CNT, 7);
        step();

        // asynchronous reset in the middle of a stall
        setd(0, 0, 0, 3, 3, 3, 20, KIND_MEM, 1'b0);
        step();
        setd(20, 0, 0, 0, 3, 3, 0, KIND_NONE, 1'b0);
        #1;
        push_exp("pre_reset_stall", S_STALL, 1);
        drain();
        #1;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset_stall", S_STALL, 0);
        push_exp("async_reset_cnt", S_CNT, 0);
        push_exp("async_reset_fwd_rs_d", S_RS_D, 0);
        drain();
        #10;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
